fx2_slavefifo_rx: RTL and testbench

//  Upstream read engine for the Cypress FX2 asynchronous slave FIFO (OUT endpoint EP2).

---
 rtl/fx2_slavefifo_rx.sv | 93 +++++++++
 tb/tb_fx2_slavefifo_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slavefifo_rx.sv
// fx2_slavefifo_rx: polls FX2 EP2 via SLOE/SLRD and buffers bytes into a valid/ready stream
module fx2_slavefifo_rx #(
    parameter int         DEPTH      = 16,
    parameter int         ADDR_SETUP = 2,
    parameter int         RD_LOW     = 3,
    parameter int         RD_HIGH    = 4,
    parameter logic [1:0] EP_ADDR    = 2'b00
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     enable,
    input  logic [7:0]               cy_fd,
    input  logic                     cy_flag_ne,
    output logic [1:0]               cy_fifoadr,
    output logic                     cy_sloe_n,
    output logic                     cy_slrd_n,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              rx_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, SETUP, RD_LO, RD_HI} state_t;
    state_t        state;
    logic [7:0]    cnt;
    logic          flag_m, flag_s;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, can_rd;
    assign push    = state == RD_LO && cnt == 8'(RD_LOW - 1);
    assign pop     = m_valid && m_ready;
    assign can_rd  = enable && flag_s && fill < (AW+1)'(DEPTH);
    assign m_valid = fill != '0;
    assign m_data  = mem[rd_ptr];
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= cy_fd;
    end
    // only one read is ever in flight, so push never meets a full buffer
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            flag_m     <= 1'b0;
            flag_s     <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            cy_fifoadr <= EP_ADDR;
            cy_sloe_n  <= 1'b1;
            cy_slrd_n  <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            rx_count   <= '0;
        end else begin
            flag_m     <= cy_flag_ne;
            flag_s     <= flag_m;
            cy_fifoadr <= EP_ADDR;
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                rx_count <= rx_count + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
            case (state)
                IDLE: if (can_rd) begin
                    state     <= SETUP;
                    cnt       <= '0;
                    cy_sloe_n <= 1'b0;
                end
                SETUP: if (cnt == 8'(ADDR_SETUP - 1)) begin
                    state     <= RD_LO;
                    cnt       <= '0;
                    cy_slrd_n <= 1'b0;
                end else cnt <= cnt + 8'd1;
                RD_LO: if (push) begin
                    state     <= RD_HI;
                    cnt       <= '0;
                    cy_slrd_n <= 1'b1;
                end else cnt <= cnt + 8'd1;
                RD_HI: if (cnt == 8'(RD_HIGH - 1)) begin
                    cnt <= '0;
                    if (can_rd) begin
                        state     <= RD_LO;
                        cy_slrd_n <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        cy_sloe_n <= 1'b1;
                    end
                end else cnt <= cnt + 8'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx2_slavefifo_rx.sv
// tb_fx2_slavefifo_rx: directed vector table plus multi-cycle sequences against an FX2 FIFO model
module tb_fx2_slavefifo_rx;
    logic        sys_clk = 1'b0, sys_rst_n = 1'b0, enable = 1'b0, m_ready = 1'b0;
    logic        cy_flag_ne = 1'b0;
    logic [7:0]  cy_fd = 8'h00;
    logic [1:0]  cy_fifoadr;
    logic        cy_sloe_n, cy_slrd_n, m_valid;
    logic [7:0]  m_data;
    logic [4:0]  fill;
    logic [15:0] rx_count;
    int          nvec = 0, nerr = 0;

    always #5 sys_clk = ~sys_clk;

    fx2_slavefifo_rx dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .cy_fd(cy_fd),
        .cy_flag_ne(cy_flag_ne), .cy_fifoadr(cy_fifoadr), .cy_sloe_n(cy_sloe_n),
        .cy_slrd_n(cy_slrd_n), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fill(fill), .rx_count(rx_count)
    );

    // FX2 EP2 model: head byte on FD, advances on SLRD rising, flag = not empty
    logic [7:0] fx_q[$];
    logic       slrd_prev = 1'b1;
    always @(negedge sys_clk) begin
        if (!slrd_prev && cy_slrd_n && fx_q.size() != 0) void'(fx_q.pop_front());
        slrd_prev  = cy_slrd_n;
        cy_flag_ne = fx_q.size() != 0;
        cy_fd      = fx_q.size() != 0 ? fx_q[0] : 8'h00;
    end

    typedef struct {
        logic       en, rdy, sloe, slrd;
        logic [4:0] fill;
        logic [7:0] data;
        logic [15:0] rx;
    } vec_t;
    vec_t vq[$];

    task automatic add(input int n, input logic en, rdy, sloe, slrd,
                       input logic [4:0] f, input logic [7:0] d, input logic [15:0] rx);
        for (int i = 0; i < n; i++) vq.push_back('{en, rdy, sloe, slrd, f, d, rx});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic reset_clear;
        sys_rst_n = 1'b0;
        enable    = 1'b0;
        m_ready   = 1'b0;
        fx_q.delete();
        repeat (3) tick;
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_slrd_low(input string name);
        int n = 0;
        while (cy_slrd_n && n < 60) begin tick; n++; end
        chk(name, cy_slrd_n, 1'b0);
    endtask

    initial begin
        int falls, n, seen;
        logic prev;
        logic [7:0] got;
        // reset with FX2 flag already high
        fx_q = '{8'h11, 8'h22, 8'h33};
        repeat (3) tick;
        chk("rst_sloe", cy_sloe_n, 1'b1);
        chk("rst_slrd", cy_slrd_n, 1'b1);
        chk("rst_fill", fill, 0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_rx", rx_count, 0);
        chk("rst_adr", cy_fifoadr, 2'b00);
        // cycle trace after release: sloe, slrd, fill, data, rx_count
        add(2, 1, 1, 1, 1, 0, 8'h00, 0);
        add(2, 1, 1, 0, 1, 0, 8'h00, 0);
        add(3, 1, 1, 0, 0, 0, 8'h00, 0);
        add(1, 1, 1, 0, 1, 1, 8'h11, 1);
        add(3, 1, 1, 0, 1, 0, 8'h00, 1);
        add(3, 1, 1, 0, 0, 0, 8'h00, 1);
        add(1, 1, 1, 0, 1, 1, 8'h22, 2);
        add(3, 1, 1, 0, 1, 0, 8'h00, 2);
        add(3, 1, 1, 0, 0, 0, 8'h00, 2);
        add(1, 1, 1, 0, 1, 1, 8'h33, 3);
        add(3, 1, 1, 0, 1, 0, 8'h00, 3);
        add(3, 1, 1, 1, 1, 0, 8'h00, 3);
        sys_rst_n = 1'b1;
        foreach (vq[i]) begin
            enable  = vq[i].en;
            m_ready = vq[i].rdy;
            tick;
            chk($sformatf("v%0d_sloe", i), cy_sloe_n, vq[i].sloe);
            chk($sformatf("v%0d_slrd", i), cy_slrd_n, vq[i].slrd);
            chk($sformatf("v%0d_fill", i), fill, vq[i].fill);
            chk($sformatf("v%0d_valid", i), m_valid, vq[i].fill != 0);
            chk($sformatf("v%0d_rx", i), rx_count, vq[i].rx);
            if (vq[i].fill != 0) chk($sformatf("v%0d_data", i), m_data, vq[i].data);
        end
        // back-pressure: 40 bytes waiting, consumer stalled
        m_ready = 1'b0;
        for (int i = 0; i < 40; i++) fx_q.push_back(8'(8'h40 + i));
        falls = 0;
        prev  = cy_slrd_n;
        repeat (200) begin tick; if (prev && !cy_slrd_n) falls++; prev = cy_slrd_n; end
        chk("full_reads", falls, 16);
        chk("full_fill", fill, 16);
        chk("full_slrd", cy_slrd_n, 1'b1);
        chk("full_sloe", cy_sloe_n, 1'b1);
        chk("full_rx", rx_count, 19);
        chk("full_head", m_data, 8'h40);
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        chk("pop1_fill", fill, 15);
        chk("pop1_head", m_data, 8'h41);
        falls = 0;
        prev  = cy_slrd_n;
        repeat (60) begin tick; if (prev && !cy_slrd_n) falls++; prev = cy_slrd_n; end
        chk("refill_reads", falls, 1);
        chk("refill_fill", fill, 16);
        chk("refill_rx", rx_count, 20);
        // simultaneous push and pop at fill=5
        reset_clear;
        for (int i = 0; i < 6; i++) fx_q.push_back(8'(8'h60 + i));
        enable = 1'b1;
        n = 0;
        while (fill != 5 && n < 100) begin tick; n++; end
        chk("pp_reach5", fill, 5);
        repeat (6) tick;
        chk("pp_pre_fill", fill, 5);
        chk("pp_pre_head", m_data, 8'h60);
        m_ready = 1'b1;
        tick;
        chk("pp_fill", fill, 5);
        chk("pp_head", m_data, 8'h61);
        for (int k = 2; k <= 5; k++) begin
            tick;
            chk($sformatf("pp_order%0d", k), m_data, 8'(8'h60 + k));
        end
        tick;
        chk("pp_drain", fill, 0);
        chk("pp_rx", rx_count, 6);
        // enable dropped during RD_LO
        reset_clear;
        fx_q = '{8'h70, 8'h71, 8'h72};
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_slrd_low("en_wait");
        enable = 1'b0;
        falls = 0;
        seen  = 0;
        got   = 8'h00;
        prev  = cy_slrd_n;
        repeat (40) begin
            tick;
            if (prev && !cy_slrd_n) falls++;
            prev = cy_slrd_n;
            if (m_valid) begin got = m_data; seen++; end
        end
        chk("en_extra_reads", falls, 0);
        chk("en_delivered", seen, 1);
        chk("en_byte", got, 8'h70);
        chk("en_rx", rx_count, 1);
        chk("en_sloe", cy_sloe_n, 1'b1);
        chk("en_slrd", cy_slrd_n, 1'b1);
        // reset during RD_LO with counter preset to 0xFFFF
        reset_clear;
        fx_q = '{8'h80, 8'h81, 8'h82};
        force dut.rx_count = 16'hFFFF;
        tick;
        release dut.rx_count;
        enable = 1'b1;
        wait_slrd_low("mr_wait");
        sys_rst_n = 1'b0;
        tick;
        chk("mr_slrd", cy_slrd_n, 1'b1);
        chk("mr_sloe", cy_sloe_n, 1'b1);
        chk("mr_fill", fill, 0);
        chk("mr_valid", m_valid, 1'b0);
        chk("mr_rx", rx_count, 0);
        sys_rst_n = 1'b1;
        force dut.rx_count = 16'hFFFF;
        tick;
        release dut.rx_count;
        n = 0;
        while (!m_valid && n < 60) begin tick; n++; end
        chk("wrap_valid", m_valid, 1'b1);
        chk("wrap_rx", rx_count, 0);
        chk("wrap_byte", m_data, 8'h81);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
